mb_decoder_seq: RTL and testbench
=================================

// Module: mb_decoder_seq
// PURPOSE
//  Iterative Modified-Booth (radix-4) to two's-complement (U2) decoder; inverse of the MB encoder.
//  Accepts one word of DIGITS MB digits as packed sign/one/two vectors and reconstructs the WIDTH-bit U2 value.
//  Processes DPC digits per clock, MSB-first, by Horner accumulation.
//  Used in the multiplier test path to check encoder output, and as the reference for recoded operands.
// PARAMETERS
//  DIGITS  16  number of MB digits per word; WIDTH = 2*DIGITS (localparam, 32 by default)
//  DPC     1   digits decoded per clock; legal values 1, 2, 4; must divide DIGITS
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       sign/one/two hold a word to decode
//  in_ready   out  1       decoder can accept a word
//  sign       in   DIGITS  digit sign, bit i = digit i (weight 4^i); 1 = negative
//  one        in   DIGITS  digit magnitude 1
//  two        in   DIGITS  digit magnitude 2
//  out_valid  out  1       result/err_digit/overflow valid
//  out_ready  in   1       consumer accepts result
//  result     out  WIDTH   decoded U2 value (low WIDTH bits of the accumulator)
//  err_digit  out  1       word contained >=1 illegal digit (one=two=1)
//  overflow   out  1       exact sum is not representable as WIDTH-bit signed
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; result=0; err_digit=0; overflow=0; accumulator, count and shift regs cleared.
//   Reset mid-RUN or mid-DONE aborts the word immediately; nothing is output.
//  Digit value: d = two ? 2 : one ? 1 : 0, negated when sign=1.
//   sign=1 with one=two=0 (-0) is legal and decodes to 0.
//   one=two=1 is illegal: it contributes 0 and sets sticky err for the word.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: in_ready=1. On in_valid&in_ready, capture sign/one/two into shift regs.
//    Also clear acc (signed, WIDTH+2 bits) and err; set cnt=DIGITS/DPC; go to RUN.
//   RUN: in_ready=0. Each clock: acc <= acc*4^DPC + sum_{k<DPC} d_top-k * 4^(DPC-1-k).
//    Take the top DPC digits of the shift regs; shift the regs left by DPC; cnt <= cnt-1.
//    On the cycle cnt reaches 0: go to DONE and register result, err_digit and overflow.
//   DONE: out_valid=1; result/flags are stable while out_ready=0; in_ready=0.
//    On out_ready: out_valid<=0 and go to IDLE. No input overlap.
//  Latency: out_valid rises exactly DIGITS/DPC clocks after the input handshake edge.
//   Throughput: one word per DIGITS/DPC+2 clocks with out_ready held high.
//  Width rules: intermediate sums fit WIDTH+2 bits (max |sum| = 2*(4^DIGITS-1)/3).
//   overflow = (acc > 2^(WIDTH-1)-1) or (acc < -2^(WIDTH-1)); result = acc[WIDTH-1:0], even on overflow.
//  Any digit set produced by the MB encoder from a WIDTH-bit U2 value decodes to that value, with err_digit=0 and overflow=0.
//  in_valid while in_ready=0 is ignored; the source holds the word until the handshake.
//  result/flags hold their last value in IDLE; only out_valid qualifies them.
// TESTING (DIGITS=16; run with DPC=1, 2 and 4)
//  1. Reset: assert rst_n=0 mid-RUN -> out_valid=0 and in_ready=1 at once; the next word decodes correctly.
//  2. sign=0x0001, one=0x0001, two=0 (encoding of -1) -> result=0xFFFFFFFF, err_digit=0, overflow=0.
//     out_valid rises 16/DPC clocks after the handshake.
//  3. Encodings of 0x80000000 (sign=0x8000, two=0x8000, one=0) and 0x7FFFFFFF (via encoder model) -> exact value, flags 0.
//  4. sign=0, one=0, two=0xFFFF -> result=0xAAAAAAAA, overflow=1.
//     Same word with one[3]=1 added -> err_digit=1; digit 3 counts 0, so result=0xAAAAAA2A.
//  5. Backpressure: out_ready=0 for 5 clocks in DONE -> out_valid, result and flags stable; in_ready=0; a pending in_valid is not taken.
//  6. 1000 random 32-bit values through the encoder model, back-to-back -> every result matches, with no lost or duplicated words.

Source files
------------

// File: rtl/mb_decoder_seq.sv
// Iterative Modified-Booth (radix-4) to two's-complement decoder.
// Consumes DPC digits per clock, MSB-first, accumulating by Horner's rule.
module mb_decoder_seq #(
    parameter int DIGITS = 16,
    parameter int DPC    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIGITS-1:0]   sign,
    input  logic [DIGITS-1:0]   one,
    input  logic [DIGITS-1:0]   two,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DIGITS-1:0] result,
    output logic                err_digit,
    output logic                overflow
);
    localparam int WIDTH = 2 * DIGITS;
    localparam int STEPS = DIGITS / DPC;
    localparam int CW    = $clog2(STEPS + 1);

    // Handshakes: a word moves on any rising edge where valid and ready are both high;
    // valid holds its payload until then, and ready never depends on valid.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [DIGITS-1:0]      sh_sign, sh_one, sh_two;
    logic signed [WIDTH+1:0] acc, acc_next, digsum, dv;
    logic [1:0]             mag;
    logic [CW-1:0]          cnt;
    logic                   err, err_now, ovf_next;

    always_comb begin
        digsum  = '0;
        err_now = 1'b0;
        mag     = 2'd0;
        dv      = '0;
        for (int k = 0; k < DPC; k++) begin
            mag = sh_two[DIGITS-1-k] ? 2'd2 : (sh_one[DIGITS-1-k] ? 2'd1 : 2'd0);
            // one=two=1 is not a legal digit: it contributes nothing but taints the word
            if (sh_one[DIGITS-1-k] && sh_two[DIGITS-1-k]) begin
                mag     = 2'd0;
                err_now = 1'b1;
            end
            dv = {{WIDTH{1'b0}}, mag};
            if (sh_sign[DIGITS-1-k])
                dv = -dv;
            digsum = digsum + (dv <<< (2 * (DPC - 1 - k)));
        end
        acc_next = (acc <<< (2 * DPC)) + digsum;
        // representable as WIDTH-bit signed iff the top three bits agree
        ovf_next = !((acc_next[WIDTH+1:WIDTH-1] == 3'b000) ||
                     (acc_next[WIDTH+1:WIDTH-1] == 3'b111));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            err_digit <= 1'b0;
            overflow  <= 1'b0;
            acc       <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            sh_sign   <= '0;
            sh_one    <= '0;
            sh_two    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_sign  <= sign;
                        sh_one   <= one;
                        sh_two   <= two;
                        acc      <= '0;
                        err      <= 1'b0;
                        cnt      <= CW'(STEPS);
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    err     <= err | err_now;
                    sh_sign <= sh_sign << DPC;
                    sh_one  <= sh_one << DPC;
                    sh_two  <= sh_two << DPC;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        result    <= acc_next[WIDTH-1:0];
                        err_digit <= err | err_now;
                        overflow  <= ovf_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mb_decoder_seq.sv
// Directed and random checks of mb_decoder_seq against an MB encoder model.
module tb_mb_decoder_seq;
    parameter int DPC = 1;
    localparam int DIGITS = 16;
    localparam int WIDTH  = 32;
    localparam int LAT    = DIGITS / DPC;
    localparam int NRAND  = 1000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DIGITS-1:0] sign, one, two;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  result;
    logic              err_digit;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];

    mb_decoder_seq #(.DIGITS(DIGITS), .DPC(DPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .one(one), .two(two),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err_digit(err_digit), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Standard radix-4 Booth recoding of a 32-bit two's-complement value
    function automatic logic [47:0] mb_encode(input logic [31:0] x);
        logic [15:0] s, o, t;
        logic b1, b0, bm;
        for (int i = 0; i < 16; i++) begin
            b1 = x[2*i+1];
            b0 = x[2*i];
            if (i == 0) bm = 1'b0;
            else        bm = x[2*i-1];
            s[i] = b1;
            o[i] = b0 ^ bm;
            t[i] = (b1 & ~b0 & ~bm) | (~b1 & b0 & bm);
        end
        return {s, o, t};
    endfunction

    // Drive one word, check latency and outputs, optionally stall the consumer for `hold` clocks
    task automatic run_word(input logic [15:0] s, input logic [15:0] o, input logic [15:0] t,
                            input logic [31:0] exp_res, input logic exp_err, input logic exp_ovf,
                            input string tag, input int hold);
        int guard;
        int lat;
        logic [31:0] res0;
        logic e0, v0;
        @(negedge clk);
        sign = s; one = o; two = t;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check({tag, "_accept_timeout"}, 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_err"}, err_digit, exp_err);
        check({tag, "_ovf"}, overflow, exp_ovf);
        res0 = result; e0 = err_digit; v0 = overflow;
        if (hold > 0) begin
            sign = ~s; one = 16'h0001; two = 16'h0;
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({tag, "_bp_valid"}, out_valid, 1);
                check({tag, "_bp_result"}, result, res0);
                check({tag, "_bp_flags"}, {err_digit, overflow}, {e0, v0});
                check({tag, "_bp_in_ready"}, in_ready, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_drain_valid"}, out_valid, 0);
        check({tag, "_drain_ready"}, in_ready, 1);
    endtask

    initial begin : main
        logic [47:0] enc;
        logic [31:0] x;
        int got;
        int cyc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sign = '0; one = '0; two = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", {err_digit, overflow}, 0);
        rst_n = 1'b1;

        // Reset in the middle of a decode aborts it immediately
        enc = mb_encode(32'h12345678);
        @(negedge clk);
        {sign, one, two} = enc;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_word(enc[47:32], enc[31:16], enc[15:0], 32'h12345678, 0, 0, "after_rst", 0);

        run_word(16'h0001, 16'h0001, 16'h0000, 32'hFFFFFFFF, 0, 0, "minus1", 0);
        run_word(16'h8000, 16'h0000, 16'h8000, 32'h80000000, 0, 0, "min_neg", 0);
        enc = mb_encode(32'h7FFFFFFF);
        run_word(enc[47:32], enc[31:16], enc[15:0], 32'h7FFFFFFF, 0, 0, "max_pos", 0);
        run_word(16'h0000, 16'h0000, 16'hFFFF, 32'hAAAAAAAA, 0, 1, "all_two", 0);
        run_word(16'h0000, 16'h0008, 16'hFFFF, 32'hAAAAAA2A, 1, 1, "illegal_d3", 0);
        run_word(16'hFFFF, 16'h0000, 16'h0000, 32'h00000000, 0, 0, "neg_zero", 0);
        run_word(16'h0000, 16'h0000, 16'h0000, 32'h00000000, 0, 0, "zero", 0);
        enc = mb_encode(32'hFFFE1DC0);
        run_word(enc[47:32], enc[31:16], enc[15:0], 32'hFFFE1DC0, 0, 0, "backpressure", 5);

        // Back-to-back random words with the consumer always ready
        out_ready = 1'b1;
        got = 0;
        fork
            begin : driver
                int guard;
                for (int n = 0; n < NRAND; n++) begin
                    @(negedge clk);
                    x = $urandom_range(32'hFFFFFFFF, 0);
                    enc = mb_encode(x);
                    {sign, one, two} = enc;
                    in_valid = 1'b1;
                    guard = 0;
                    while (!in_ready && guard < 200) begin
                        @(negedge clk);
                        guard++;
                    end
                    @(posedge clk);
                    exp_q.push_back(x);
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin : monitor
                logic [31:0] e;
                cyc = 0;
                while (got < NRAND && cyc < NRAND * (LAT + 4) + 200) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (out_valid) begin
                        if (exp_q.size() == 0) begin
                            check("rand_spurious_output", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("rand_result", result, e);
                            check("rand_flags", {err_digit, overflow}, 0);
                        end
                        got++;
                    end
                end
            end
        join
        check("rand_words_received", got, NRAND);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
